// File: rtl/gate_vector_checker_if.sv
// Control/status bundle for gate_vector_checker: run request in, progress and verdict out.
// The master side requests runs; the slave side (the checker) reports results.
interface gate_vector_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       fail_vec;

  modport master (
    output start,
    input  busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    input  start,
    output busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/gate_vector_checker.sv
// Drives a 2-input gate through all four input vectors, samples its output after a
// settle interval and compares it against an expected truth table.
module gate_vector_checker #(
  parameter int       SETTLE = 2,
  parameter int       CNT_W  = 8,
  parameter logic [3:0] EXPECT = 4'b0001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_vector_checker_if.slave ctl,
  output logic                 a,
  output logic                 b,
  input  logic                 y
);

  localparam int WCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [1:0]         idx_r, idx_nxt_s;
  logic [1:0]         ab_r, ab_nxt_s;
  logic [WCNT_W-1:0]  wcnt_r, wcnt_nxt_s;
  logic [CNT_W-1:0]   err_cnt_r, err_cnt_nxt_s;
  logic [3:0]         fail_vec_r, fail_vec_nxt_s;
  logic               pass_r, pass_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;

  // Next-state and next-output computation for the vector sequencer
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    ab_nxt_s       = ab_r;
    wcnt_nxt_s     = wcnt_r;
    err_cnt_nxt_s  = err_cnt_r;
    fail_vec_nxt_s = fail_vec_r;
    pass_nxt_s     = pass_r;

    case (state_r)
      ST_IDLE: begin
        if (ctl.start) begin
          state_nxt_s    = ST_WAIT;
          idx_nxt_s      = 2'd0;
          ab_nxt_s       = 2'b00;
          wcnt_nxt_s     = {WCNT_W{1'b0}};
          err_cnt_nxt_s  = {CNT_W{1'b0}};
          fail_vec_nxt_s = 4'b0000;
          pass_nxt_s     = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wcnt_r == WCNT_W'(SETTLE - 1)) begin
          state_nxt_s = ST_SAMPLE;
          wcnt_nxt_s  = {WCNT_W{1'b0}};
        end else begin
          wcnt_nxt_s  = wcnt_r + {{(WCNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_SAMPLE: begin
        if (y != EXPECT[idx_r]) begin
          fail_vec_nxt_s[idx_r] = 1'b1;
          if (err_cnt_r != {CNT_W{1'b1}}) begin
            err_cnt_nxt_s = err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            err_cnt_nxt_s = err_cnt_r;
          end
        end else begin
          fail_vec_nxt_s = fail_vec_r;
        end
        // The verdict must include a mismatch on the last vector, hence the next value
        if (idx_r == 2'd3) begin
          state_nxt_s = ST_DONE;
          pass_nxt_s  = (err_cnt_nxt_s == {CNT_W{1'b0}});
        end else begin
          state_nxt_s = ST_WAIT;
          idx_nxt_s   = idx_r + 2'd1;
          ab_nxt_s    = idx_r + 2'd1;
          wcnt_nxt_s  = {WCNT_W{1'b0}};
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_SAMPLE);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= 2'd0;
      ab_r       <= 2'b00;
      wcnt_r     <= {WCNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
      fail_vec_r <= 4'b0000;
      pass_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      ab_r       <= ab_nxt_s;
      wcnt_r     <= wcnt_nxt_s;
      err_cnt_r  <= err_cnt_nxt_s;
      fail_vec_r <= fail_vec_nxt_s;
      pass_r     <= pass_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign a            = ab_r[1];
  assign b            = ab_r[0];
  assign ctl.busy     = busy_r;
  assign ctl.done     = done_r;
  assign ctl.pass     = pass_r;
  assign ctl.err_cnt  = err_cnt_r;
  assign ctl.fail_vec = fail_vec_r;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized bench for gate_vector_checker: a NOR gate model with injectable faults
// drives y, and a truth-table reference predicts timing and verdicts.
module tb_gate_vector_checker;

  localparam int SETTLE = 2;
  localparam int HOLD   = SETTLE + 1;
  localparam int RUN    = 4 * HOLD;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, y, a1, b1;
  logic force_en, force_val;
  logic [3:0] flip;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gate_vector_checker_if #(.CNT_W(8)) ctl  ();
  gate_vector_checker_if #(.CNT_W(1)) ctl1 ();

  // Gate under test: NOR with per-vector output flips, or stuck at a constant
  assign y = force_en ? force_val : (~(a | b) ^ flip[{a, b}]);

  gate_vector_checker #(.SETTLE(SETTLE), .CNT_W(8), .EXPECT(4'b0001)) dut (
    .clk(clk), .rst_n(rst_n), .ctl(ctl.slave), .a(a), .b(b), .y(y)
  );

  gate_vector_checker #(.SETTLE(SETTLE), .CNT_W(1), .EXPECT(4'b0001)) dut1 (
    .clk(clk), .rst_n(rst_n), .ctl(ctl1.slave), .a(a1), .b(b1), .y(y)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    ctl.start  = v;
    ctl1.start = v;
  endtask

  // One full run: per-cycle a/b/busy/done timing, then the verdict from the truth table
  task automatic run_vectors(input logic fe, input logic fv, input logic [3:0] fl, input bit hold);
    logic [3:0] mism;
    int         nerr;
    int         waited;
    logic       nor_i, yv;
    force_en  = fe;
    force_val = fv;
    flip      = fl;
    nerr      = 0;
    for (int i = 0; i < 4; i++) begin
      nor_i   = (i == 0);
      yv      = fe ? fv : (nor_i ^ fl[i]);
      mism[i] = (yv != nor_i);
      nerr   += (yv != nor_i) ? 1 : 0;
    end
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    for (int k = 0; k <= RUN; k++) begin
      #1;
      if (!hold) set_start(1'b0);
      check_val("ab_seq", {30'd0, a, b}, (k < RUN) ? (k / HOLD) : 3);
      check_val("busy", ctl.busy, (k < RUN) ? 1 : 0);
      check_val("done", ctl.done, (k == RUN) ? 1 : 0);
      check_val("done_w1", ctl1.done, (k == RUN) ? 1 : 0);
      if (k < RUN) begin
        check_val("pass_mid", ctl.pass, 0);
        @(posedge clk);
      end
    end
    check_val("pass", ctl.pass, (nerr == 0) ? 1 : 0);
    check_val("err_cnt", ctl.err_cnt, nerr);
    check_val("fail_vec", ctl.fail_vec, mism);
    check_val("pass_w1", ctl1.pass, (nerr == 0) ? 1 : 0);
    check_val("err_cnt_w1", ctl1.err_cnt, (nerr > 0) ? 1 : 0);
    check_val("fail_vec_w1", ctl1.fail_vec, mism);
    @(posedge clk);
    #1;
    check_val("idle_done", ctl.done, 0);
    check_val("idle_busy", ctl.busy, 0);
    check_val("idle_hold_err", ctl.err_cnt, nerr);
    check_val("idle_hold_pass", ctl.pass, (nerr == 0) ? 1 : 0);
    if (hold) begin
      // start still high: the second run begins only now, from IDLE
      @(posedge clk);
      #1;
      check_val("rerun_busy", ctl.busy, 1);
      check_val("rerun_err_clr", ctl.err_cnt, 0);
      check_val("rerun_fail_clr", ctl.fail_vec, 0);
      set_start(1'b0);
      waited = 0;
      while (!ctl.done && waited < RUN + 4) begin
        @(posedge clk);
        #1;
        waited++;
      end
      check_val("rerun_done", ctl.done, 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ab"}, {30'd0, a, b}, 0);
    check_val({tag, "_busy"}, ctl.busy, 0);
    check_val({tag, "_done"}, ctl.done, 0);
    check_val({tag, "_pass"}, ctl.pass, 0);
    check_val({tag, "_err"}, ctl.err_cnt, 0);
    check_val({tag, "_fail"}, ctl.fail_vec, 0);
  endtask

  initial begin
    int done_seen;
    rst_n     = 1'b0;
    force_en  = 1'b0;
    force_val = 1'b0;
    flip      = 4'b0000;
    set_start(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_vectors(1'b0, 1'b0, 4'b0000, 1'b0);  // ideal NOR
    run_vectors(1'b1, 1'b0, 4'b0000, 1'b0);  // stuck at 0
    run_vectors(1'b1, 1'b1, 4'b0000, 1'b0);  // stuck at 1, also saturates the 1-bit counter
    run_vectors(1'b0, 1'b0, 4'b0000, 1'b0);  // rerun clears results
    run_vectors(1'b0, 1'b0, 4'b0110, 1'b1);  // start held for the whole run

    // Reset in the middle of a run
    force_en  = 1'b1;
    force_val = 1'b0;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_val("mid_ab", {30'd0, a, b}, 1);
    check_val("mid_err", ctl.err_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < RUN + 4; c++) begin
      @(posedge clk);
      #1;
      if (ctl.done || ctl1.done) done_seen++;
    end
    check_val("abort_no_done", done_seen, 0);
    check_val("abort_idle_busy", ctl.busy, 0);
    run_vectors(1'b0, 1'b0, 4'b0000, 1'b0);

    // Random fault patterns
    for (int r = 0; r < 10; r++) begin
      run_vectors(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
